// File: rtl/user_interface_pkg.sv
// user_interface_pkg
//   Shared defaults and types for the drum-pattern user interface.
//   UI_PATTERN_WIDTH     steps per drum pattern
//   UI_COUNT_WIDTH       width of the half-step position counter n
//   UI_DRUM_COUNT        number of drum voices / stored patterns
//   UI_DRUM_COUNT_WIDTH  width of the drum select
//   pattern_t            one stored pattern; MSB is step 0
package user_interface_pkg;

  localparam int UI_PATTERN_WIDTH    = 8;
  localparam int UI_COUNT_WIDTH      = 4;
  localparam int UI_DRUM_COUNT       = 5;
  localparam int UI_DRUM_COUNT_WIDTH = 3;

  typedef logic [UI_PATTERN_WIDTH-1:0] pattern_t;

endpackage

// File: rtl/drum_pattern_reg.sv
// drum_pattern_reg
//   One drum's pattern register plus its playback bit selection.
//   clk        rising-edge clock
//   rst        asynchronous active-low clear of the register
//   i_load     load i_pattern on the next rising edge
//   i_pattern  pattern to store (MSB = step 0)
//   i_n        half-step position; step = i_n >> 1, phase = i_n[0]
//   o_bit      trigger for this drum at position i_n (combinational)
module drum_pattern_reg
  import user_interface_pkg::*;
#(
  parameter int PATTERN_WIDTH = UI_PATTERN_WIDTH,
  parameter int COUNT_WIDTH   = UI_COUNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load,
  input  logic [PATTERN_WIDTH-1:0] i_pattern,
  input  logic [COUNT_WIDTH-1:0]   i_n,
  output logic                     o_bit
);

  logic [PATTERN_WIDTH-1:0] r_pat;
  logic [COUNT_WIDTH-2:0]   w_step;
  logic                     w_step_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_pat <= '0;
    else if (i_load) r_pat <= i_pattern;
  end

  assign w_step = i_n[COUNT_WIDTH-1:1];

  // Search over legal steps: a step index past the pattern end matches
  // nothing and leaves the bit at 0.
  always_comb begin
    w_step_bit = 1'b0;
    for (int i = 0; i < PATTERN_WIDTH; i++)
      if (int'(w_step) == i) w_step_bit = r_pat[PATTERN_WIDTH-1-i];
  end

  // Second half of every step is forced low so back-to-back hits on
  // consecutive steps still produce separate pulses.
  assign o_bit = w_step_bit & ~i_n[0];

endmodule

// File: rtl/user_interface.sv
// user_interface
//   Drum sequencer pattern store: DRUM_COUNT pattern registers written one
//   at a time, all read out in parallel at the current half-step position.
//   clk        rising-edge clock
//   rst        asynchronous active-low reset, clears every pattern
//   pattern_i  pattern to write (MSB = step 0)
//   sel_i      drum to write; values >= DRUM_COUNT are ignored
//   en_i_n     active-low write enable
//   n          half-step playback position
//   pattern_o  per-drum trigger at position n (combinational)
module user_interface
  import user_interface_pkg::*;
#(
  parameter int PATTERN_WIDTH    = UI_PATTERN_WIDTH,
  parameter int COUNT_WIDTH      = UI_COUNT_WIDTH,
  parameter int DRUM_COUNT       = UI_DRUM_COUNT,
  parameter int DRUM_COUNT_WIDTH = UI_DRUM_COUNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PATTERN_WIDTH-1:0]    pattern_i,
  input  logic [DRUM_COUNT_WIDTH-1:0] sel_i,
  input  logic                        en_i_n,
  input  logic [COUNT_WIDTH-1:0]      n,
  output logic                        pattern_o [0:DRUM_COUNT-1]
);

  logic [DRUM_COUNT-1:0] w_we;
  logic [DRUM_COUNT-1:0] w_bit;

  for (genvar d = 0; d < DRUM_COUNT; d++) begin : g_drum
    // Out-of-range selects match no instance, so such writes are dropped.
    assign w_we[d] = ~en_i_n & (int'(sel_i) == d);

    drum_pattern_reg #(
      .PATTERN_WIDTH (PATTERN_WIDTH),
      .COUNT_WIDTH   (COUNT_WIDTH)
    ) u_reg (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_we[d]),
      .i_pattern (pattern_i),
      .i_n       (n),
      .o_bit     (w_bit[d])
    );

    assign pattern_o[d] = w_bit[d];
  end

endmodule

// File: tb/tb_user_interface.sv
module tb_user_interface;
  import user_interface_pkg::*;

  localparam int PW  = 8;
  localparam int CW  = 4;
  localparam int DC  = 5;
  localparam int DCW = 3;

  logic           clk = 1'b0;
  logic           rst;
  pattern_t       pattern_i;
  logic [DCW-1:0] sel_i;
  logic           en_i_n;
  logic [CW-1:0]  n;
  logic           pattern_o [0:DC-1];

  pattern_t model [DC];
  logic     sb [$];
  int       tests = 0;
  int       fails = 0;

  user_interface #(
    .PATTERN_WIDTH    (PW),
    .COUNT_WIDTH      (CW),
    .DRUM_COUNT       (DC),
    .DRUM_COUNT_WIDTH (DCW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pattern_i (pattern_i),
    .sel_i     (sel_i),
    .en_i_n    (en_i_n),
    .n         (n),
    .pattern_o (pattern_o)
  );

  always #5 clk = ~clk;

  // Reference trigger: odd positions are the gated-off half step.
  function automatic logic ref_bit(pattern_t p, int nn);
    if (nn % 2 != 0) return 1'b0;
    if (nn / 2 >= PW) return 1'b0;
    return p[PW-1-nn/2];
  endfunction

  task automatic check(string tag, int d);
    logic exp;
    exp = sb.pop_front();
    tests++;
    assert (pattern_o[d] === exp)
    else begin
      fails++;
      $error("FAIL %s drum%0d n=%0d got %b exp %b", tag, d, n, pattern_o[d], exp);
    end
  endtask

  // Expect every drum from the model at position nn.
  task automatic probe(string tag, int nn);
    n = CW'(nn);
    for (int d = 0; d < DC; d++) sb.push_back(ref_bit(model[d], nn));
    #1;
    for (int d = 0; d < DC; d++) check(tag, d);
  endtask

  // Expect one drum against a fixed constant at position nn.
  task automatic probe1(string tag, int nn, int d, logic exp);
    n = CW'(nn);
    sb.push_back(exp);
    #1;
    check(tag, d);
  endtask

  task automatic wr(int sel, pattern_t pat);
    @(negedge clk);
    sel_i     = DCW'(sel);
    pattern_i = pat;
    en_i_n    = 1'b0;
    @(posedge clk);
    if (sel < DC) model[sel] = pat;
    #1 en_i_n = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < DC; d++) model[d] = '0;
    rst = 1'b0; en_i_n = 1'b0; n = '0; sel_i = '0; pattern_i = '0;

    // Reset holds with writes being attempted
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      pattern_i = pattern_t'($urandom);
      sel_i     = DCW'($urandom_range(0, DC-1));
    end
    for (int nn = 0; nn < 16; nn++) probe("reset", nn);
    @(negedge clk);
    en_i_n = 1'b1;
    rst    = 1'b1;

    // Disabled write leaves drum 2 clear
    @(negedge clk);
    pattern_i = 8'hFF; sel_i = 3'd2; en_i_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int nn = 0; nn < 16; nn++) probe1("enable", nn, 2, 1'b0);

    // Write/readback of 1001_1010 on every drum
    for (int s = 0; s < DC; s++) begin
      wr(s, 8'b1001_1010);
      probe1("wr_n0",  0,  s, 1'b1);
      probe1("wr_n2",  2,  s, 1'b0);
      probe1("wr_n6",  6,  s, 1'b1);
      probe1("wr_n8",  8,  s, 1'b1);
      probe1("wr_n14", 14, s, 1'b0);
    end

    // Gate phase on a solid pattern
    wr(0, 8'hFF);
    for (int nn = 0; nn < 16; nn++) probe1("gate", nn, 0, (nn % 2 == 0));
    for (int nn = 0; nn < 16; nn++) probe("sweep", nn);

    // Mid-operation asynchronous reset
    for (int s = 0; s < DC; s++) wr(s, 8'hFF);
    probe("allff", 0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int d = 0; d < DC; d++) model[d] = '0;
    probe("midrst", 0);
    @(negedge clk);
    rst = 1'b1;

    // Isolation and out-of-range select
    wr(3, 8'h80);
    wr(5, 8'hFF);
    wr(7, 8'hFF);
    for (int d = 0; d < DC; d++) probe1("iso_n0", 0, d, (d == 3));
    probe("iso_n2", 2);

    // Same-cycle write/read: old value until the edge, new value after
    @(negedge clk);
    n = '0; sel_i = 3'd3; pattern_i = 8'h00; en_i_n = 1'b0;
    sb.push_back(1'b1);
    #1 check("old", 3);
    @(posedge clk);
    model[3] = 8'h00;
    sb.push_back(1'b0);
    #1 check("new", 3);
    en_i_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
